// File: rtl/hier_node_pkg.sv
// Shared types, defaults and helpers for the parametrised hierarchy node.
package hier_node_pkg;

    localparam int unsigned HIER_NUM_INST_DEF = 10;
    localparam int unsigned HIER_DATA_W_DEF   = 16;
    localparam int unsigned HIER_MAX_INST     = 256;
    localparam int unsigned HIER_IDX_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SCAN,
        ST_DONE
    } hier_scan_state_e;

    typedef struct packed {
        logic                  found;
        logic [HIER_IDX_W-1:0] idx;
    } hier_next_t;

    // Lowest set bit of mask strictly above from; from = -1 yields the lowest set bit overall.
    function automatic hier_next_t next_set_idx(input logic [HIER_MAX_INST-1:0] mask,
                                                input int                       from);
        hier_next_t res;
        res = '0;
        for (int i = int'(HIER_MAX_INST) - 1; i >= 0; i--) begin
            if (mask[i] && (i > from)) begin
                res.found = 1'b1;
                res.idx   = HIER_IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hier_node_array_leaf.sv
// Leaf unit: wrapping event counter plus a snapshot register.
// HIER_NODE_CLEAR_ON_SNAP_EN: when defined, the counter restarts from zero on every snapshot.
module hier_leaf
    import hier_node_pkg::*;
#(
    parameter int unsigned DATA_W = HIER_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              snap_req,
    output logic [DATA_W-1:0] snap_q
);

    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + DATA_W'(1);
        end
`ifdef HIER_NODE_CLEAR_ON_SNAP_EN
        // Clearing wins over an increment landing in the snapshot cycle.
        if (snap_req) begin
            count_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            snap_q  <= '0;
        end else begin
            count_q <= count_d;
            if (snap_req) begin
                snap_q <= count_q;
            end
        end
    end

endmodule

// File: rtl/hier_node_array.sv
// Array of leaf counters with a snapshot/scan controller streaming enabled leaves over valid/ready.
// Build option HIER_NODE_CLEAR_ON_SNAP_EN (see hier_leaf) selects clear-on-snapshot counting.
module hier_node_array
    import hier_node_pkg::*;
#(
    parameter int unsigned NUM_INST = HIER_NUM_INST_DEF,
    parameter int unsigned DATA_W   = HIER_DATA_W_DEF,
    parameter int unsigned ID_W     = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_INST-1:0] enable,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_W-1:0]     out_id,
    output logic [DATA_W-1:0]   out_data,
    output logic                busy,
    output logic                done
);

    hier_scan_state_e    state_q, state_d;
    logic [NUM_INST-1:0] mask_q, mask_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic                out_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                snap_req;
    hier_next_t          nxt;
    logic [DATA_W-1:0]   snap_w [NUM_INST];

    assign snap_req = (state_q == ST_SNAP);

    for (genvar g = 0; g < int'(NUM_INST); g++) begin : g_leaf
        hier_leaf #(
            .DATA_W(DATA_W)
        ) u_leaf (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (enable[g]),
            .snap_req(snap_req),
            .snap_q  (snap_w[g])
        );
    end

    // Next-state: pointer always sits on a set mask bit, so scanning never emits bubbles.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        nxt     = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                mask_d  = enable;
                nxt     = next_set_idx(HIER_MAX_INST'(enable), -1);
                ptr_d   = ID_W'(nxt.idx);
                state_d = nxt.found ? ST_SCAN : ST_DONE;
            end
            ST_SCAN: begin
                if (out_ready) begin
                    nxt = next_set_idx(HIER_MAX_INST'(mask_q), int'(ptr_q));
                    if (nxt.found) begin
                        ptr_d = ID_W'(nxt.idx);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            out_valid_q <= (state_d == ST_SCAN);
            busy_q      <= (state_d == ST_SNAP) || (state_d == ST_SCAN);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = ptr_q;
    assign out_data  = snap_w[ptr_q];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hier_node_array.sv
// Directed bench for hier_node_array: scoreboard of expected scan words plus cycle-accurate checks.
module tb_hier_node_array;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  enable;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    logic        b_start;
    logic [1:0]  b_enable;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [0:0]  b_out_id;
    logic [3:0]  b_out_data;
    logic        b_busy;
    logic        b_done;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          done_seen    = 0;
    int          done_cyc     = -1;
    int          words_seen   = 0;
    int          first_valid_cyc = -1;
    bit          hold_pending = 1'b0;
    logic [3:0]  hold_id;
    logic [15:0] hold_data;
    bit          clear_now    = 1'b0;
    logic [15:0] cnt [10];
    exp_t        exp_q [$];

    always #5 clk = ~clk;

    hier_node_array u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .enable   (enable),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_id   (out_id),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    hier_node_array #(
        .NUM_INST(2),
        .DATA_W  (4)
    ) u_dut_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (b_start),
        .enable   (b_enable),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_id   (b_out_id),
        .out_data (b_out_data),
        .busy     (b_busy),
        .done     (b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks outputs of the current cycle, then advances one clock and updates the counter model.
    task automatic tick();
        exp_t e;
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_id", 32'(out_id), 32'(hold_id));
            check("hold_data", 32'(out_data), 32'(hold_data));
        end
        hold_pending = (out_valid === 1'b1) && (out_ready === 1'b0);
        hold_id      = out_id;
        hold_data    = out_data;
        if (out_valid === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_ready) begin
                words_seen++;
                tests_run++;
                assert (exp_q.size() > 0) else begin
                    tests_failed++;
                    $error("FAIL word_expected: observed id %0d, expected no word", out_id);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("word_id", 32'(out_id), 32'(e.id));
                    check("word_data", 32'(out_data), 32'(e.data));
                end
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
            check("busy_at_done", 32'(busy), 32'd0);
        end
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            if (clear_now) cnt[i] = 16'd0;
            else if (enable[i]) cnt[i] = cnt[i] + 16'd1;
        end
        clear_now = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 0,0,1 from the first scan cycle.
    task automatic run_scan(input int mode, input bit pulse_start);
        int c0;
        int k;
        done_seen       = 0;
        words_seen      = 0;
        first_valid_cyc = -1;
        c0    = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_snap", 32'(busy), 32'd1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (enable[i]) begin
                exp_q.push_back({4'(i), cnt[i]});
                k++;
            end
        end
`ifdef HIER_NODE_CLEAR_ON_SNAP_EN
        clear_now = 1'b1;
`endif
        for (int n = 0; n < 200 && done_seen == 0; n++) begin
            if (mode == 0) out_ready = 1'b1;
            else           out_ready = ((cyc - c0 - 2) % 3 == 2);
            start = pulse_start && (cyc == c0 + 3);
            tick();
        end
        start = 1'b0;
        check("done_seen", 32'(done_seen), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'(c0 + 2 + ((mode == 1) ? 3 : 1) * k));
        check("word_count", 32'(words_seen), 32'(k));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_after_scan", 32'(busy), 32'd0);
        if (k > 0) check("first_valid_cycle", 32'(first_valid_cyc), 32'(c0 + 2));
    endtask

    initial begin
        for (int i = 0; i < 10; i++) cnt[i] = 16'd0;
        rst_n       = 1'b0;
        start       = 1'b0;
        enable      = '0;
        out_ready   = 1'b0;
        b_start     = 1'b0;
        b_enable    = '0;
        b_out_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_b_valid", 32'(b_out_valid), 32'd0);
        check("rst_b_data", 32'(b_out_data), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        rst_n = 1'b1;

        // Basic: all leaves counted 5 cycles, start pulse during SCAN must be ignored.
        enable    = '1;
        out_ready = 1'b1;
        repeat (5) tick();
        run_scan(0, 1'b1);
        repeat (2) begin
            check("start_ignored", 32'(busy), 32'd0);
            tick();
        end

        // Sparse mask: ids 0, 5, 9 back-to-back.
        enable = 10'b10_0010_0001;
        repeat (3) tick();
        run_scan(0, 1'b0);

        // Backpressure 0,0,1.
        enable = 10'b01_1001_0110;
        repeat (2) tick();
        run_scan(1, 1'b0);

        // Empty mask.
        enable = '0;
        tick();
        run_scan(0, 1'b0);

        // Small instance: 4-bit wrap and snapshot-clear behaviour on leaf 0.
        b_enable = 2'b01;
        repeat (16) tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_busy_snap", 32'(b_busy), 32'd1);
        tick();
        b_enable = 2'b00;
        check("b_valid1", 32'(b_out_valid), 32'd1);
        check("b_id1", 32'(b_out_id), 32'd0);
        check("b_wrap_data", 32'(b_out_data), 32'd1);
        tick();
        check("b_done1", 32'(b_done), 32'd1);
        check("b_valid_after1", 32'(b_out_valid), 32'd0);
        tick();
        b_enable = 2'b01;
        repeat (2) tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        b_enable = 2'b00;
        check("b_valid2", 32'(b_out_valid), 32'd1);
`ifdef HIER_NODE_CLEAR_ON_SNAP_EN
        check("b_second_data", 32'(b_out_data), 32'd3);
`else
        check("b_second_data", 32'(b_out_data), 32'd5);
`endif
        tick();
        check("b_done2", 32'(b_done), 32'd1);
        tick();

        // Reset mid-SCAN: immediate clear, no done pulse.
        enable    = '1;
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_id", 32'(out_id), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 10; i++) cnt[i] = 16'd0;
        hold_pending = 1'b0;
        enable       = '0;
        done_seen    = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("no_done_after_rst", 32'(done_seen), 32'd0);

        // Recovery scan after reset.
        enable = '1;
        repeat (2) tick();
        run_scan(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hier_node_array.md
# hier_node_array

Parametrised successor to the fixed ten-child hierarchy node. It instantiates `NUM_INST` leaf units in a generate loop. Each leaf keeps an event counter. A scan controller snapshots all leaves on request and streams the enabled leaves' values out over a valid/ready port. The block sits one level below the root and gives the hierarchy an observable, per-channel status path.

## Interface
Parameters:
- `NUM_INST`, 10: number of leaf instances (≥1).
- `DATA_W`, 16: leaf counter and output data width.
- `ID_W`, `$clog2(NUM_INST)` (min 1): derived width of the leaf index; not overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  scan request, sampled only in IDLE.
- `enable`  in  NUM_INST  per-leaf count enable; also the scan mask, latched at SNAP.
- `out_valid`  out  1  snapshot word available.
- `out_ready`  in  1  downstream accepts the word.
- `out_id`  out  ID_W  leaf index of the current word.
- `out_data`  out  DATA_W  snapshot value of that leaf.
- `busy`  out  1  high in SNAP and SCAN.
- `done`  out  1  one-cycle pulse when a scan completes.

Reset values: `out_valid`=0, `out_id`=0, `out_data`=0, `busy`=0, `done`=0. All leaf counters, snapshots, the scan pointer and the mask reset to 0. FSM resets to IDLE.

## Operation
- Leaf i: `count` increments by 1 each cycle `enable[i]`=1. It wraps from 2^DATA_W−1 to 0. It never saturates.
- FSM states: IDLE, SNAP, SCAN, DONE.
- IDLE: `start`=1 moves to SNAP. `start` in any other state is ignored, not queued.
- SNAP (1 cycle): every leaf copies `count` into `snap`. `enable` is latched into `mask`. The pointer is set to the lowest set bit of `mask`. If `mask`=0, go to DONE; otherwise go to SCAN.
- SCAN: `out_valid`=1, `out_id`=pointer, `out_data`=snap[pointer].
  - On `out_valid && out_ready`, the pointer moves to the next higher set bit of `mask`.
  - If no higher bit is set, go to DONE.
  - Disabled leaves are skipped with no bubble cycles.
- DONE (1 cycle): `done`=1, then return to IDLE.
- While `out_valid`=1 and `out_ready`=0, `out_id` and `out_data` hold stable.
- `out_valid` never drops without a handshake.
- Leaf counters keep counting during SNAP, SCAN and DONE. Snapshots are frozen from SNAP until the next SNAP.
- Changing `enable` mid-scan affects counting only, not the scan order.
- Asserting `rst_n` low at any point, including mid-scan, returns everything to reset values immediately. The interrupted scan is abandoned with no `done` pulse.

## Timing
- Cycle 0: `start`=1 in IDLE. Cycle 1: SNAP, `busy`=1; snapshot holds the counts as registered at the end of cycle 1. Cycle 2: first `out_valid`.
- With `out_ready` held at 1: one word per cycle. For k enabled leaves, `done` pulses at cycle 2+k and `busy` falls in the same cycle.
- With `mask`=0: `done` at cycle 2, no `out_valid`.
- Earliest next accepted `start`: cycle after DONE.

## Configuration
- Macro: `HIER_NODE_CLEAR_ON_SNAP_EN`.
- Defined: in SNAP, each leaf loads `count` with 0 in the same edge that captures `snap`. An increment in that cycle is discarded. Each scan reports the events since the previous snapshot.
- Undefined: counters free-run. Scans report cumulative, wrapping totals.

## Structure
- Package `hier_node_pkg`:
  - FSM state enum `hier_scan_state_e`.
  - Default constants `HIER_NUM_INST_DEF`=10 and `HIER_DATA_W_DEF`=16.
  - Function `next_set_idx(mask, from)`, which returns the lowest set bit above `from` plus a found flag.
- Sub-module `hier_leaf`:
  - Parameter `DATA_W`.
  - Ports `clk`, `rst_n`, `en`, `snap_req`, `snap_q`.
  - Contains the counter and snapshot register.
- The top holds the FSM, mask and pointer, plus a generate loop of `NUM_INST` `hier_leaf` instances.

## Test plan
- Basic scan, NUM_INST=10, all enabled for 5 cycles before `start` and `out_ready`=1. Each `out_data` = 6 in that default config. Words come in ids 0..9 on consecutive cycles; `done` at cycle 12.
- Sparse mask, `enable`=10'b10_0010_0001 → words only for ids 0, 5, 9, back-to-back, no gaps. `done` 1 cycle after id 9 is accepted.
- Backpressure, `out_ready` toggled 0,0,1 repeatedly → each word held stable for 3 cycles. No word dropped or duplicated.
- Wrap and config, DATA_W=4, leaf 0 enabled 17 cycles → snapshot 1. With `HIER_NODE_CLEAR_ON_SNAP_EN`, a second scan after 3 more enabled cycles reports 3 (2 if the SNAP cycle overlaps).
- Edge cases:
  - `mask`=0 → `done` at cycle 2, no `out_valid`.
  - `start` pulsed during SCAN → ignored.
  - `rst_n` low mid-SCAN → all outputs 0 next sample, no `done`.
